// File: rtl/cdb_arbiter_if.sv
// Producer/CDB signal bundle for cdb_arbiter: two result sources in (valid/ready), one registered broadcast out.
// slave = arbiter side, master = producer/consumer side.
interface cdb_arbiter_if #(
    parameter int ROB_ID_WIDTH = 4,
    parameter int DATA_WIDTH   = 32
);
    logic                    alu_valid;
    logic [ROB_ID_WIDTH-1:0] alu_rob_id;
    logic [DATA_WIDTH-1:0]   alu_data;
    logic                    alu_ready;
    logic                    lsu_valid;
    logic [ROB_ID_WIDTH-1:0] lsu_rob_id;
    logic [DATA_WIDTH-1:0]   lsu_data;
    logic                    lsu_ready;
    logic                    cdb_valid;
    logic [ROB_ID_WIDTH-1:0] cdb_rob_id;
    logic [DATA_WIDTH-1:0]   cdb_data;
    logic                    cdb_src;

    modport slave (
        input  alu_valid, alu_rob_id, alu_data, lsu_valid, lsu_rob_id, lsu_data,
        output alu_ready, lsu_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_src
    );

    modport master (
        output alu_valid, alu_rob_id, alu_data, lsu_valid, lsu_rob_id, lsu_data,
        input  alu_ready, lsu_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over per-source result FIFOs; accepted result broadcasts after edge E+1 at the earliest.
// Ready = FIFO not full (registered counts only); optional counters under `ifdef CDB_ARB_STATS_EN.
module cdb_arbiter #(
    parameter int ROB_ID_WIDTH = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          rollback_flag_from_rob,
    cdb_arbiter_if.slave  bus
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]   stat_conflict_cnt,
    output logic [31:0]   stat_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0] rob_id;
        logic [DATA_WIDTH-1:0]   data;
    } res_t;

    // Index 0 is the ALU source, index 1 the LSU source.
    res_t             mem_q   [2][FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q  [2];
    logic [PTR_W-1:0] wptr_d  [2];
    logic [PTR_W-1:0] rptr_q  [2];
    logic [PTR_W-1:0] rptr_d  [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    res_t             in_dat  [2];

    logic       last_q, last_d;
    logic       cdb_vld_q, cdb_vld_d;
    res_t       cdb_dat_q, cdb_dat_d;
    logic       cdb_src_q, cdb_src_d;
    logic [1:0] in_vld, full, nonempty, push, pop;
    logic       flush, grant_any, grant_src;

    assign flush     = rst_in | rollback_flag_from_rob;
    assign in_vld    = {bus.lsu_valid, bus.alu_valid};
    assign in_dat[0] = {bus.alu_rob_id, bus.alu_data};
    assign in_dat[1] = {bus.lsu_rob_id, bus.lsu_data};

    assign bus.alu_ready  = ~full[0];
    assign bus.lsu_ready  = ~full[1];
    assign bus.cdb_valid  = cdb_vld_q;
    assign bus.cdb_rob_id = cdb_dat_q.rob_id;
    assign bus.cdb_data   = cdb_dat_q.data;
    assign bus.cdb_src    = cdb_src_q;

    // On conflict the source that did not win last time gets the bus.
    assign grant_any = |nonempty;
    assign grant_src = (&nonempty) ? ~last_q : nonempty[1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            full[s]     = (cnt_q[s] == CNT_W'(FIFO_DEPTH));
            nonempty[s] = (cnt_q[s] != '0);
            push[s]     = rdy_in & in_vld[s] & ~full[s];
            pop[s]      = rdy_in & grant_any & (grant_src == 1'(s));
            wptr_d[s]   = wptr_q[s] + PTR_W'(push[s]);
            rptr_d[s]   = rptr_q[s] + PTR_W'(pop[s]);
            cnt_d[s]    = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
        end
        cdb_vld_d = cdb_vld_q;
        cdb_dat_d = cdb_dat_q;
        cdb_src_d = cdb_src_q;
        last_d    = last_q;
        if (rdy_in) begin
            cdb_vld_d = grant_any;
            if (grant_any) begin
                cdb_dat_d = mem_q[grant_src][rptr_q[grant_src]];
                cdb_src_d = grant_src;
                last_d    = grant_src;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (flush) begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            last_q    <= 1'b1;
            cdb_vld_q <= 1'b0;
            cdb_dat_q <= '0;
            cdb_src_q <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
                cnt_q[s]  <= cnt_d[s];
            end
            last_q    <= last_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_dat_q <= cdb_dat_d;
            cdb_src_q <= cdb_src_d;
        end
    end

    // Storage needs no reset: counts and pointers alone define occupancy.
    always_ff @(posedge clk_in) begin
        if (!flush) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    mem_q[s][wptr_q[s]] <= in_dat[s];
                end
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [31:0] conflict_q, stall_q;

    assign stat_conflict_cnt = conflict_q;
    assign stat_stall_cnt    = stall_q;

    // Rollback deliberately leaves these alone; only rst_in clears them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else if (rdy_in) begin
            if ((&nonempty) && (conflict_q != 32'hFFFF_FFFF)) begin
                conflict_q <= conflict_q + 32'd1;
            end
            if (((in_vld & full) != 2'b00) && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end
`endif
endmodule
